i2c_slave_regfile: RTL

- Byte-wide I2C register file slave that attaches to the on-chip I2C frontend bus.
- Generalises the single-register write-only slave:
  - 2^PTR_BITS registers, each 8 bits wide.
  - A host-loaded address pointer that auto-increments and wraps.
  - Both write and read transfers are supported.
- Register contents are exposed as a flat bus. A one-cycle strobe marks each committed write.

---
 rtl/i2c_slave_regfile.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/i2c_slave_regfile.sv
// Byte-wide I2C register file slave for the on-chip frontend bus: a pointer byte
// selects a register, later bytes write or read successive registers with wrap.
module i2c_slave_regfile #(
  parameter logic [6:0] I2C_ADDRESS   = 7'h00,
  parameter int         PTR_BITS      = 3,
  parameter logic [7:0] DEFAULT_VALUE = 8'h00
) (
  input  logic                            clk,
  input  logic                            reset,
  output logic [1:0]                      i2c_interface_tx,
  input  logic [20:0]                     i2c_interface_rx,
  output logic [8*(2**PTR_BITS)-1:0]      reg_out,
  output logic                            write_strobe,
  output logic [PTR_BITS-1:0]             write_index
);

  localparam int NUM_REGS = 2**PTR_BITS;
  localparam logic [PTR_BITS-1:0] PTR_ONE = PTR_BITS'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPECT_PTR,
    ST_WRITE_DATA,
    ST_READ_DATA
  } state_t;

  logic       rx_stop;
  logic       rx_content;
  logic       content_strobe;
  logic [8:0] bit_count;
  logic [6:0] pkt_address;
  logic       pkt_read_wr;
  logic       pkt_addressed;

  assign {rx_stop, rx_content, content_strobe, bit_count,
          pkt_address, pkt_read_wr, pkt_addressed} = i2c_interface_rx;

  state_t              state_q, state_d;
  logic [PTR_BITS-1:0] ptr_q, ptr_d;
  logic [7:0]          shift_q, shift_d;
  logic [7:0]          regs_q [NUM_REGS];
  logic [7:0]          regs_d [NUM_REGS];
  logic                write_strobe_q, write_strobe_d;
  logic [PTR_BITS-1:0] write_index_q, write_index_d;
  logic                dev_addr_prev_q, dev_addr_prev_d;

  logic       dev_addressed;
  logic       addr_rise;
  logic       byte_done;
  logic [7:0] new_byte;
  logic       writing;
  logic       reading;
  logic [7:0] rd_byte;
  logic [2:0] bit_sel;
  logic       tx_content;
  logic       ack;

  always_comb begin
    dev_addressed   = pkt_addressed && (pkt_address == I2C_ADDRESS);
    addr_rise       = dev_addressed && !dev_addr_prev_q;
    byte_done       = content_strobe && (bit_count[2:0] == 3'd7);
    new_byte        = {shift_q[6:0], rx_content};
    dev_addr_prev_d = dev_addressed;

    state_d        = state_q;
    ptr_d          = ptr_q;
    shift_d        = shift_q;
    regs_d         = regs_q;
    write_strobe_d = 1'b0;
    write_index_d  = write_index_q;

    // Leaving the bus (stop, repeated start, other device) drops any partial byte.
    if (!dev_addressed || rx_stop) begin
      state_d = ST_IDLE;
      shift_d = '0;
    end else if (addr_rise) begin
      state_d = pkt_read_wr ? ST_READ_DATA : ST_EXPECT_PTR;
      shift_d = '0;
    end else begin
      unique case (state_q)
        ST_EXPECT_PTR: begin
          if (content_strobe) shift_d = new_byte;
          if (byte_done) begin
            ptr_d   = new_byte[PTR_BITS-1:0];
            state_d = ST_WRITE_DATA;
          end
        end
        ST_WRITE_DATA: begin
          if (content_strobe) shift_d = new_byte;
          if (byte_done) begin
            regs_d[ptr_q]  = new_byte;
            write_strobe_d = 1'b1;
            write_index_d  = ptr_q;
            ptr_d          = ptr_q + PTR_ONE;
          end
        end
        ST_READ_DATA: begin
          if (byte_done) ptr_d = ptr_q + PTR_ONE;
        end
        default: ;
      endcase
    end
  end

  // Outputs are gated by the transfer state so bits after a mid-transfer reset are ignored.
  always_comb begin
    writing    = dev_addressed && !pkt_read_wr &&
                 ((state_q == ST_EXPECT_PTR) || (state_q == ST_WRITE_DATA));
    reading    = dev_addressed && pkt_read_wr && (state_q == ST_READ_DATA);
    rd_byte    = regs_q[ptr_q];
    bit_sel    = 3'd7 - bit_count[2:0];
    tx_content = reading ? rd_byte[bit_sel] : 1'b1;
    ack        = writing || (reading && (bit_count == 9'd7));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      ptr_q           <= '0;
      shift_q         <= '0;
      regs_q          <= '{default: DEFAULT_VALUE};
      write_strobe_q  <= 1'b0;
      write_index_q   <= '0;
      // Held high so an address phase already in progress is not seen as a new one.
      dev_addr_prev_q <= 1'b1;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      shift_q         <= shift_d;
      regs_q          <= regs_d;
      write_strobe_q  <= write_strobe_d;
      write_index_q   <= write_index_d;
      dev_addr_prev_q <= dev_addr_prev_d;
    end
  end

  for (genvar n = 0; n < NUM_REGS; n++) begin : g_out
    assign reg_out[8*n +: 8] = regs_q[n];
  end

  assign i2c_interface_tx = {tx_content, ack};
  assign write_strobe     = write_strobe_q;
  assign write_index      = write_index_q;

endmodule
